// File: rtl/intp_service_master.sv
// intp_service_master
// Processor-side partner of intp_ctrl. First, as an APB initiator, it writes the priority
// register of every peripheral from prio_map_i and can then read each register back to
// verify it. After a clean configuration it services interrupts: it latches the pending
// ID, waits SERVICE_CYCLES cycles, pulses intp_serviced_o, and then waits for
// intp_valid_i to drop before it accepts the next interrupt.
//
// Ports
//   pclk_i, prst_i        clock; asynchronous active-low reset
//   start_i               begin configuration (accepted in idle only)
//   prio_map_i            priority of peripheral i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_done_o/error_o    configuration status, cleared by the next accepted start
//   paddr_o .. penable_o  APB request outputs
//   prdata_i, pready_i,   APB completion inputs
//   perror_i
//   intp_valid_i,         pending interrupt and its ID from intp_ctrl
//   intp_to_service_i
//   intp_serviced_o       one-cycle service acknowledge
//   serviced_id_o         ID of the current or last serviced interrupt
//   service_count_o       number of serviced interrupts (wraps)
module intp_service_master #(
  parameter int unsigned NUM_OF_PERIPHERALS = 16,
  parameter int unsigned ADDR_WIDTH         = 4,
  parameter int unsigned DATA_WIDTH         = 4,
  parameter int unsigned SERVICE_CYCLES     = 3,
  parameter int unsigned PREADY_TIMEOUT     = 15,
  parameter bit          VERIFY             = 1'b1
) (
  input  logic                                     pclk_i,
  input  logic                                     prst_i,
  input  logic                                     start_i,
  input  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] prio_map_i,
  output logic                                     cfg_done_o,
  output logic                                     cfg_error_o,
  output logic [ADDR_WIDTH-1:0]                    paddr_o,
  output logic                                     pwrite_o,
  output logic [DATA_WIDTH-1:0]                    pwdata_o,
  output logic                                     penable_o,
  input  logic [DATA_WIDTH-1:0]                    prdata_i,
  input  logic                                     pready_i,
  input  logic                                     perror_i,
  input  logic                                     intp_valid_i,
  input  logic [DATA_WIDTH-1:0]                    intp_to_service_i,
  output logic                                     intp_serviced_o,
  output logic [DATA_WIDTH-1:0]                    serviced_id_o,
  output logic [15:0]                              service_count_o
);

  localparam int unsigned TW = $clog2(PREADY_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SERVICE_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StWrSetup, StWrAccess, StRdSetup, StRdAccess, StReady, StService, StAck, StWaitLow
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [TW-1:0]           tcnt_q;
  logic [SW-1:0]           scnt_q;

  logic [ADDR_WIDTH-1:0]   idx_inc;
  logic [DATA_WIDTH-1:0]   cur_prio;
  logic [DATA_WIDTH-1:0]   nxt_prio;
  logic                    last_idx;
  logic                    rd_bad;

  always_comb begin
    idx_inc  = idx_q + 1'b1;
    cur_prio = prio_map_i[DATA_WIDTH*int'(idx_q) +: DATA_WIDTH];
    // Data for the next write is loaded while leaving the current access.
    nxt_prio = prio_map_i[DATA_WIDTH*int'(idx_inc) +: DATA_WIDTH];
    last_idx = (idx_q == ADDR_WIDTH'(NUM_OF_PERIPHERALS - 1));
    rd_bad   = (state_q == StRdAccess) && (prdata_i != cur_prio);
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      tcnt_q          <= '0;
      scnt_q          <= '0;
      cfg_done_o      <= 1'b0;
      cfg_error_o     <= 1'b0;
      paddr_o         <= '0;
      pwrite_o        <= 1'b0;
      pwdata_o        <= '0;
      penable_o       <= 1'b0;
      intp_serviced_o <= 1'b0;
      serviced_id_o   <= '0;
      service_count_o <= '0;
    end else begin
      intp_serviced_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            cfg_done_o  <= 1'b0;
            cfg_error_o <= 1'b0;
            idx_q       <= '0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b1;
            pwdata_o    <= prio_map_i[DATA_WIDTH-1:0];
            state_q     <= StWrSetup;
          end
        end
        StWrSetup, StRdSetup: begin
          penable_o <= 1'b1;
          tcnt_q    <= '0;
          state_q   <= (state_q == StWrSetup) ? StWrAccess : StRdAccess;
        end
        StWrAccess, StRdAccess: begin
          if (pready_i) begin
            penable_o <= 1'b0;
            if (perror_i || rd_bad) begin
              cfg_error_o <= 1'b1;
              state_q     <= StIdle;
            end else if (last_idx) begin
              idx_q <= '0;
              if (state_q == StWrAccess && VERIFY) begin
                paddr_o  <= '0;
                pwrite_o <= 1'b0;
                state_q  <= StRdSetup;
              end else begin
                cfg_done_o <= 1'b1;
                state_q    <= StReady;
              end
            end else begin
              idx_q   <= idx_inc;
              paddr_o <= idx_inc;
              if (state_q == StWrAccess) begin
                pwdata_o <= nxt_prio;
                state_q  <= StWrSetup;
              end else begin
                state_q <= StRdSetup;
              end
            end
          end else if (tcnt_q == TW'(PREADY_TIMEOUT - 1)) begin
            penable_o   <= 1'b0;
            cfg_error_o <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        StReady: begin
          if (intp_valid_i) begin
            serviced_id_o <= intp_to_service_i;
            scnt_q        <= '0;
            state_q       <= StService;
          end
        end
        StService: begin
          if (scnt_q == SW'(SERVICE_CYCLES - 1)) begin
            intp_serviced_o <= 1'b1;
            service_count_o <= service_count_o + 16'd1;
            state_q         <= StAck;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        StAck: state_q <= StWaitLow;
        // A valid that stays high belongs to the interrupt just serviced.
        StWaitLow: begin
          if (!intp_valid_i) state_q <= StReady;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
